// File: rtl/rle_decoder.sv
// rle_decoder
// Expands a stream of run-length tokens into DCT coefficient samples.
// A literal token passes its value straight through; a run token expands
// into N zero samples. Samples are grouped into blocks of BLOCK_LEN, and
// out_last marks the final sample of each block. A run that would cross a
// block boundary is cut short at the block end, and the sticky err flag is
// raised.
//
// Ports
//   clk        - clock; all state changes happen on its rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - a token is present on in_is_run / in_data
//   in_ready   - the decoder accepts the token this cycle
//   in_is_run  - 1 = zero-run token, 0 = literal coefficient
//   in_data    - literal value, or the run count in its low RUN_W bits
//   out_valid  - out_data holds a sample
//   out_ready  - downstream consumes the sample
//   out_data   - reconstructed coefficient
//   out_last   - the held sample is index BLOCK_LEN-1 of its block
//   err        - sticky run-overflow flag, cleared only by reset
module rle_decoder #(
    parameter int width     = 11,
    parameter int RUN_W     = 8,
    parameter int BLOCK_LEN = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_is_run,
    input  logic signed [width-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [width-1:0] out_data,
    output logic                    out_last,
    output logic                    err
);

    localparam int IDX_W = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_LEN - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                  state, state_n;
    logic [RUN_W-1:0]        run_left, run_left_n;
    logic [IDX_W-1:0]        idx, idx_n;
    logic                    out_valid_n;
    logic                    out_last_n;
    logic                    err_n;
    logic signed [width-1:0] out_data_n;

    logic                    load_ok;
    logic                    at_last;
    logic [RUN_W-1:0]        run_cnt;
    logic [IDX_W-1:0]        idx_inc;

    // idx is the block position the next loaded sample will take, so the
    // out_last flag can be registered together with the sample itself.
    assign run_cnt = in_data[RUN_W-1:0];
    assign load_ok = !out_valid || out_ready;
    assign at_last = (idx == LAST_IDX);
    assign idx_inc = at_last ? '0 : idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            run_left  <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            run_left  <= run_left_n;
            idx       <= idx_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            out_last  <= out_last_n;
            err       <= err_n;
        end
    end

    // The output register is reloaded only when it is empty or being
    // consumed this cycle; otherwise everything holds, which keeps a
    // stalled sample stable and stops a run from advancing.
    always_comb begin
        state_n     = state;
        run_left_n  = run_left;
        idx_n       = idx;
        out_valid_n = out_valid;
        out_data_n  = out_data;
        out_last_n  = out_last;
        err_n       = err;
        in_ready    = 1'b0;

        case (state)
            IDLE: begin
                in_ready = load_ok;
                if (load_ok) begin
                    out_valid_n = 1'b0;
                    out_last_n  = 1'b0;
                    if (in_valid) begin
                        if (!in_is_run) begin
                            out_valid_n = 1'b1;
                            out_data_n  = in_data;
                            out_last_n  = at_last;
                            idx_n       = idx_inc;
                        end else if (run_cnt != '0) begin
                            out_valid_n = 1'b1;
                            out_data_n  = '0;
                            out_last_n  = at_last;
                            idx_n       = idx_inc;
                            // More zeros follow: either keep running, or,
                            // when this zero already closes the block, drop
                            // the rest and flag the overflow.
                            if (run_cnt > RUN_W'(1)) begin
                                if (at_last) begin
                                    err_n = 1'b1;
                                end else begin
                                    run_left_n = run_cnt - 1'b1;
                                    state_n    = RUN;
                                end
                            end
                        end
                    end
                end
            end

            RUN: begin
                if (load_ok) begin
                    out_valid_n = 1'b1;
                    out_data_n  = '0;
                    out_last_n  = at_last;
                    idx_n       = idx_inc;
                    run_left_n  = run_left - 1'b1;
                    // Loading the final zero ends the run even if it lands
                    // exactly on the block end; only surplus zeros are an
                    // overflow.
                    if (run_left == RUN_W'(1)) begin
                        state_n = IDLE;
                    end else if (at_last) begin
                        err_n      = 1'b1;
                        run_left_n = '0;
                        state_n    = IDLE;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rle_decoder.sv
module tb_rle_decoder;

    localparam int W  = 11;
    localparam int RW = 8;
    localparam int BL = 64;

    typedef struct {
        logic signed [W-1:0] d;
        logic                l;
    } exp_t;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic                in_is_run;
    logic signed [W-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_data;
    logic                out_last;
    logic                err;

    int   checks;
    int   failures;
    int   cyc;
    int   xfer_cyc;
    int   acc_cyc;
    int   ready_mode;
    bit   force_ready;
    int   pos;
    bit   err_exp;
    exp_t sb[$];

    rle_decoder #(
        .width    (W),
        .RUN_W    (RW),
        .BLOCK_LEN(BL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_is_run(in_is_run),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .err      (err)
    );

    // Free-running clock with rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count rising edges so latencies can be measured in cycles.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Hard time limit so a stuck handshake can never hang the run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted token appends its samples to the
    // expected stream, using only the block position, the run length and
    // plain arithmetic.
    task automatic modelAccept(input logic is_run, input logic [W-1:0] data);
        int   n;
        int   k;
        exp_t e;
        if (!is_run) begin
            e.d = data;
            e.l = (pos == BL - 1);
            sb.push_back(e);
            pos = (pos + 1) % BL;
        end else begin
            n = int'(data[RW-1:0]);
            k = (n < BL - pos) ? n : BL - pos;
            for (int i = 0; i < k; i++) begin
                e.d = '0;
                e.l = (pos == BL - 1);
                sb.push_back(e);
                pos = (pos + 1) % BL;
            end
            if (n > k) err_exp = 1'b1;
        end
    endtask

    // Offer one token until it is accepted; attempts counts the cycles used.
    task automatic applyStimulus(input logic is_run, input logic [W-1:0] data, output int attempts);
        bit done;
        bit accepted;
        done     = 1'b0;
        attempts = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_is_run = is_run;
            in_data   = data;
            #4;
            accepted = in_ready;
            if (accepted) begin
                acc_cyc = cyc;
                modelAccept(is_run, data);
            end
            @(posedge clk);
            #1;
            attempts++;
            if (accepted) done = 1'b1;
        end
        in_valid = 1'b0;
        if (!done) checkOutput("accept_timeout", 0, 1);
    endtask

    // Wait for the expected stream to empty, then confirm nothing extra follows.
    task automatic drain();
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            #5;
            if (sb.size() == 0) ok = 1'b1;
        end
        if (!ok) checkOutput("drain_timeout", sb.size(), 0);
        @(posedge clk);
        #1;
        checkOutput("drain_idle_valid", out_valid, 0);
    endtask

    // Downstream ready pattern: always ready, random, or a forced level.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = force_ready;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output transfer and checks that
    // a stalled sample stays put.
    initial begin
        bit                  held;
        logic signed [W-1:0] held_data;
        logic                held_last;
        exp_t                e;
        held = 1'b0;
        held_data = '0;
        held_last = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    checkOutput("hold_valid", out_valid, 1);
                    checkOutput("hold_data", out_data, held_data);
                    checkOutput("hold_last", out_last, held_last);
                end
                checkOutput("in_ready_while_stalled", in_ready && out_valid && !out_ready, 0);
                held      = out_valid && !out_ready;
                held_data = out_data;
                held_last = out_last;
                if (out_valid && out_ready) begin
                    xfer_cyc = cyc;
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_sample", out_data, 0);
                        checkOutput("unexpected_sample_count", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("sample_data", out_data, e.d);
                        checkOutput("sample_last", out_last, e.l);
                    end
                end
            end
        end
    end

    initial begin
        int              att;
        int              first_acc;
        int              seen;
        int              n;
        logic            r;
        logic [W-1:0]    d;

        checks      = 0;
        failures    = 0;
        xfer_cyc    = 0;
        acc_cyc     = 0;
        ready_mode  = 0;
        force_ready = 1'b1;
        pos         = 0;
        err_exp     = 1'b0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_is_run   = 1'b0;
        in_data     = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_out_last", out_last, 0);
        checkOutput("reset_err", err, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("reset_in_ready", in_ready, 1);

        // Literals 5, -3, 7 back to back with one-cycle latency
        $display("[TB] literal stream");
        applyStimulus(1'b0, W'(5), att);
        first_acc = acc_cyc;
        checkOutput("lit5_attempts", att, 1);
        applyStimulus(1'b0, W'(-3), att);
        checkOutput("lit_m3_attempts", att, 1);
        applyStimulus(1'b0, W'(7), att);
        checkOutput("lit7_attempts", att, 1);
        drain();
        checkOutput("lit_stream_cycles", xfer_cyc - first_acc, 3);

        // Run of 4 then literal 9 with no bubble
        $display("[TB] run 4 then literal");
        applyStimulus(1'b1, W'(4), att);
        first_acc = acc_cyc;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #4;
            checkOutput("run4_in_ready_low", in_ready, 0);
        end
        applyStimulus(1'b0, W'(9), att);
        checkOutput("lit9_attempts", att, 1);
        drain();
        checkOutput("run4_lit9_cycles", xfer_cyc - first_acc, 5);

        // Empty run produces nothing and no error
        $display("[TB] empty run");
        applyStimulus(1'b1, W'(0), att);
        applyStimulus(1'b0, W'(2), att);
        drain();
        checkOutput("empty_run_err", err, err_exp);

        // Run of 3 under backpressure
        $display("[TB] run under backpressure");
        ready_mode  = 2;
        force_ready = 1'b0;
        applyStimulus(1'b1, W'(3), att);
        repeat (6) @(negedge clk);
        force_ready = 1'b1;
        drain();
        ready_mode = 0;

        // Reset pulsed during the third zero of a run of 10
        $display("[TB] reset mid-run");
        applyStimulus(1'b1, W'(10), att);
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        pos     = 0;
        err_exp = 1'b0;
        #1;
        checkOutput("async_reset_valid", out_valid, 0);
        checkOutput("async_reset_data", out_data, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("release_in_ready", in_ready, 1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            #2;
            if (out_valid) seen++;
        end
        checkOutput("zeros_after_reset", seen, 0);

        // Run crossing the block boundary: 62 literals then run of 5
        $display("[TB] block boundary truncation");
        for (int i = 0; i < BL - 2; i++) begin
            d = W'($urandom);
            applyStimulus(1'b0, d, att);
        end
        applyStimulus(1'b1, W'(5), att);
        applyStimulus(1'b0, W'(1), att);
        drain();
        checkOutput("truncation_err", err, err_exp);
        checkOutput("truncation_next_pos", pos, 1);

        // Randomized traffic from a clean reset
        $display("[TB] random traffic");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        pos     = 0;
        err_exp = 1'b0;
        @(negedge clk);
        #1;
        rst_n      = 1'b1;
        ready_mode = 1;
        for (int t = 0; t < 300; t++) begin
            d = W'($urandom);
            r = ($urandom_range(0, 9) < 4);
            if (r) begin
                n = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 80) : $urandom_range(0, 6);
                d[RW-1:0] = RW'(n);
            end
            applyStimulus(r, d, att);
        end
        drain();
        checkOutput("random_err", err, err_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
